// File: rtl/gpu_prim_assembler.sv
// Vertex/primitive assembler: groups vertex commands into points, lines,
// triangles or triangle strips and queues finished primitives in a small FIFO.
module gpu_prim_assembler #(
    parameter int unsigned VERTEX_WIDTH = 30,
    parameter int unsigned COLOR_WIDTH  = 16,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET,
    input  logic                    I_Valid,
    input  logic [2:0]              I_Cmd,
    input  logic [1:0]              I_Mode,
    input  logic [VERTEX_WIDTH-1:0] I_Vertex,
    input  logic [COLOR_WIDTH-1:0]  I_Color,
    output logic                    O_Ready,
    output logic                    O_PrimValid,
    input  logic                    I_PrimReady,
    output logic [1:0]              O_PrimMode,
    output logic [VERTEX_WIDTH-1:0] O_PrimV1,
    output logic [VERTEX_WIDTH-1:0] O_PrimV2,
    output logic [VERTEX_WIDTH-1:0] O_PrimV3,
    output logic [COLOR_WIDTH-1:0]  O_PrimColor,
    output logic [CNT_WIDTH-1:0]    O_Count,
    output logic [2:0]              O_Error
);

    localparam int unsigned PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ENTRY_WIDTH = 2 + 3 * VERTEX_WIDTH + COLOR_WIDTH;
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);

    localparam logic [2:0] CMD_BEGIN    = 3'd1;
    localparam logic [2:0] CMD_VERTEX   = 3'd2;
    localparam logic [2:0] CMD_END      = 3'd3;
    localparam logic [2:0] CMD_SETCOLOR = 3'd4;

    localparam logic [1:0] MODE_POINT = 2'd0;
    localparam logic [1:0] MODE_LINE  = 2'd1;
    localparam logic [1:0] MODE_STRIP = 2'd3;

    typedef enum logic {StIdle, StCollect} state_e;

    state_e                  r_state, w_state_nxt;
    logic [1:0]              r_mode, w_mode_nxt;
    logic [1:0]              r_idx, w_idx_nxt, w_idx_inc, w_need;
    logic [VERTEX_WIDTH-1:0] r_s1, r_s2, r_s3, w_s1_nxt, w_s2_nxt, w_s3_nxt;
    logic [VERTEX_WIDTH-1:0] w_push_v1, w_push_v2, w_push_v3;
    logic [COLOR_WIDTH-1:0]  r_color, w_color_nxt;
    logic [2:0]              r_error, w_error_nxt;
    logic                    w_accept, w_push, w_pop;
    logic [ENTRY_WIDTH-1:0]  w_push_entry, w_head;

    logic [ENTRY_WIDTH-1:0]  r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]    r_wptr, r_rptr;
    logic [CNT_WIDTH-1:0]    r_count;

    // Ready looks only at the registered count; a same-cycle pop is ignored.
    assign O_Ready     = (r_count < CNT_WIDTH'(DEPTH));
    assign O_PrimValid = (r_count != '0);
    assign O_Count     = r_count;
    assign O_Error     = r_error;
    assign w_accept    = I_Valid & O_Ready;
    assign w_pop       = O_PrimValid & I_PrimReady;

    assign w_need       = (r_mode == MODE_POINT) ? 2'd1 : (r_mode == MODE_LINE) ? 2'd2 : 2'd3;
    assign w_idx_inc    = r_idx + 2'd1;
    assign w_push_entry = {r_mode, w_push_v1, w_push_v2, w_push_v3, r_color};

    assign w_head      = r_mem[r_rptr];
    assign O_PrimMode  = w_head[ENTRY_WIDTH-2 +: 2];
    assign O_PrimV1    = w_head[COLOR_WIDTH+2*VERTEX_WIDTH +: VERTEX_WIDTH];
    assign O_PrimV2    = w_head[COLOR_WIDTH+VERTEX_WIDTH +: VERTEX_WIDTH];
    assign O_PrimV3    = w_head[COLOR_WIDTH +: VERTEX_WIDTH];
    assign O_PrimColor = w_head[COLOR_WIDTH-1:0];

    // Command decode: next state, staging updates, error flags and push request.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_idx_nxt   = r_idx;
        w_s1_nxt    = r_s1;
        w_s2_nxt    = r_s2;
        w_s3_nxt    = r_s3;
        w_color_nxt = r_color;
        w_error_nxt = r_error;
        w_push      = 1'b0;
        w_push_v1   = '0;
        w_push_v2   = '0;
        w_push_v3   = '0;
        if (w_accept) begin
            case (I_Cmd)
                CMD_BEGIN: begin
                    if (r_state == StCollect) w_error_nxt[1] = 1'b1;
                    w_mode_nxt  = I_Mode;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = StCollect;
                end
                CMD_VERTEX: begin
                    if (r_state == StIdle) begin
                        w_error_nxt[0] = 1'b1;
                    end else if (r_mode == MODE_STRIP && r_idx == 2'd3) begin
                        // Strip steady state: slide the window and emit every vertex.
                        w_s1_nxt  = r_s2;
                        w_s2_nxt  = r_s3;
                        w_s3_nxt  = I_Vertex;
                        w_push    = 1'b1;
                        w_push_v1 = r_s2;
                        w_push_v2 = r_s3;
                        w_push_v3 = I_Vertex;
                    end else begin
                        case (r_idx)
                            2'd0:    w_s1_nxt = I_Vertex;
                            2'd1:    w_s2_nxt = I_Vertex;
                            default: w_s3_nxt = I_Vertex;
                        endcase
                        if (w_idx_inc == w_need) begin
                            w_push    = 1'b1;
                            w_idx_nxt = (r_mode == MODE_STRIP) ? 2'd3 : 2'd0;
                            case (w_need)
                                2'd1: w_push_v1 = I_Vertex;
                                2'd2: begin
                                    w_push_v1 = r_s1;
                                    w_push_v2 = I_Vertex;
                                end
                                default: begin
                                    w_push_v1 = r_s1;
                                    w_push_v2 = r_s2;
                                    w_push_v3 = I_Vertex;
                                end
                            endcase
                        end else begin
                            w_idx_nxt = w_idx_inc;
                        end
                    end
                end
                CMD_END: begin
                    if (r_state == StCollect) begin
                        if (r_idx != 2'd0 && r_idx < w_need) w_error_nxt[2] = 1'b1;
                        w_state_nxt = StIdle;
                        w_idx_nxt   = 2'd0;
                    end
                end
                CMD_SETCOLOR: w_color_nxt = I_Color;
                default: ;
            endcase
        end
    end

    // Assembly state registers.
    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            r_state <= StIdle;
            r_mode  <= 2'd0;
            r_idx   <= 2'd0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_color <= '0;
            r_error <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_idx   <= w_idx_nxt;
            r_s1    <= w_s1_nxt;
            r_s2    <= w_s2_nxt;
            r_s3    <= w_s3_nxt;
            r_color <= w_color_nxt;
            r_error <= w_error_nxt;
        end
    end

    // Primitive FIFO: circular buffer, push and pop may coincide.
    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_push_entry;
                r_wptr        <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_WIDTH'(1);
            end
            if (w_pop) r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_WIDTH'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
